// File: rtl/conv1d_pkg.sv
// Shared types and constants for the conv1d output packer and its word FIFO.
package conv1d_pkg;

  localparam int unsigned BYTE_SIZE      = 8;
  localparam int unsigned INT32_SIZE     = 32;
  localparam int unsigned LANES_PER_WORD = 4;

  typedef enum logic {
    FL_IDLE,
    FL_PEND
  } flush_state_t;

  typedef logic [INT32_SIZE-1:0] word_t;

endpackage

// File: rtl/conv1d_word_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata reads zero while empty.
module conv1d_word_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/conv1d_out_packer.sv
// Packs four int8 results little-endian per 32-bit word into a FWFT word FIFO.
// Define CONV1D_OUT_PACKER_SAT_CHECK_EN to saturate out-of-range inputs and add sat_err.
module conv1d_out_packer #(
  parameter int unsigned INT32_SIZE = 32,
  parameter int unsigned BYTE_SIZE  = 8,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT32_SIZE-1:0] in_data,
  input  logic                  flush,
  output logic                  flush_busy,
  input  logic                  rd_en,
  output logic [INT32_SIZE-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
`ifdef CONV1D_OUT_PACKER_SAT_CHECK_EN
  output logic                  sat_err,
`endif
  output logic [1:0]            lane
);

  import conv1d_pkg::*;

  localparam int unsigned PartW = 3 * BYTE_SIZE;

  flush_state_t            state_q, state_d;
  logic [1:0]              lane_q, lane_d;
  logic [PartW-1:0]        partial_q, partial_d;
  logic [BYTE_SIZE-1:0]    byte_in;
  logic [INT32_SIZE-1:0]   merged;
  logic [INT32_SIZE-1:0]   fifo_wdata;
  logic                    fifo_push;
  logic                    fifo_full, fifo_empty;
  logic                    accept;

  assign flush_busy = (state_q == FL_PEND);
  assign in_ready   = ((lane_q != 2'd3) || !fifo_full) && !flush_busy;
  assign accept     = in_valid && in_ready;
  assign lane       = lane_q;
  assign full       = fifo_full;
  assign empty      = fifo_empty;

`ifdef CONV1D_OUT_PACKER_SAT_CHECK_EN
  logic sat_hi, sat_lo, sat_err_q, sat_err_d;

  assign sat_hi = $signed(in_data) > 127;
  assign sat_lo = $signed(in_data) < -128;

  always_comb begin
    byte_in = in_data[BYTE_SIZE-1:0];
    if (sat_hi) byte_in = 8'h7F;
    if (sat_lo) byte_in = 8'h80;
  end

  // A saturating accept in the same cycle as a clearing flush leaves the flag set.
  always_comb begin
    sat_err_d = sat_err_q;
    if (flush && (state_q == FL_IDLE)) sat_err_d = 1'b0;
    if (accept && (sat_hi || sat_lo))  sat_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_err_q <= 1'b0;
    else        sat_err_q <= sat_err_d;
  end

  assign sat_err = sat_err_q;
`else
  logic unused_in_data_hi;

  assign byte_in           = in_data[BYTE_SIZE-1:0];
  assign unused_in_data_hi = ^in_data[INT32_SIZE-1:BYTE_SIZE];
`endif

  // Partial word with this cycle's byte (if any) dropped into its lane; upper lanes stay zero.
  always_comb begin
    merged = {{(INT32_SIZE - PartW){1'b0}}, partial_q};
    if (accept) merged[BYTE_SIZE*lane_q +: BYTE_SIZE] = byte_in;
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    partial_d  = partial_q;
    fifo_push  = 1'b0;
    fifo_wdata = merged;

    if (accept) begin
      lane_d    = lane_q + 1'b1;
      partial_d = merged[PartW-1:0];
    end

    if (accept && (lane_q == 2'd3)) begin
      fifo_push = 1'b1;
      lane_d    = 2'd0;
      partial_d = '0;
    end else begin
      unique case (state_q)
        FL_IDLE: begin
          if (flush && ((lane_q != 2'd0) || accept)) begin
            if (!fifo_full) begin
              fifo_push = 1'b1;
              lane_d    = 2'd0;
              partial_d = '0;
            end else begin
              state_d = FL_PEND;
            end
          end
        end
        FL_PEND: begin
          if (!fifo_full) begin
            fifo_push = 1'b1;
            lane_d    = 2'd0;
            partial_d = '0;
            state_d   = FL_IDLE;
          end
        end
        default: state_d = FL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FL_IDLE;
      lane_q    <= 2'd0;
      partial_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      partial_q <= partial_d;
    end
  end

  conv1d_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INT32_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (rd_en),
    .rdata (rd_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_conv1d_out_packer.sv
// Directed bench for conv1d_out_packer with a queue-based reference model checked every cycle.
module tb_conv1d_out_packer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, flush_busy, empty, full;
  logic [31:0] rd_data;
  logic [6:0]  count;
  logic [1:0]  lane;
`ifdef CONV1D_OUT_PACKER_SAT_CHECK_EN
  logic        sat_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  conv1d_out_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .flush_busy (flush_busy),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
`ifdef CONV1D_OUT_PACKER_SAT_CHECK_EN
    .sat_err    (sat_err),
`endif
    .lane       (lane)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending bytes, queued words, pending-flush flag, sticky saturation flag.
  logic [7:0]  m_bytes[$];
  logic [31:0] m_words[$];
  bit          m_pend = 1'b0;
  bit          m_sat = 1'b0;
  bit          m_acc, m_was_full, m_pop;

  function automatic bit out_of_range(input logic [31:0] d);
    return ($signed(d) > 127) || ($signed(d) < -128);
  endfunction

  function automatic logic [7:0] to_byte(input logic [31:0] d);
`ifdef CONV1D_OUT_PACKER_SAT_CHECK_EN
    if ($signed(d) > 127)  return 8'h7F;
    if ($signed(d) < -128) return 8'h80;
`endif
    return d[7:0];
  endfunction

  function automatic logic [31:0] pad_word();
    logic [31:0] w = '0;
    foreach (m_bytes[i]) w[8*i +: 8] = m_bytes[i];
    return w;
  endfunction

  function automatic bit m_ready();
    return ((m_bytes.size() != 3) || (m_words.size() != DEPTH)) && !m_pend;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bytes.delete();
      m_words.delete();
      m_pend = 1'b0;
      m_sat  = 1'b0;
    end else begin
      m_acc      = in_valid && m_ready();
      m_was_full = (m_words.size() == DEPTH);
      m_pop      = rd_en && (m_words.size() != 0);
      if (flush && !m_pend) m_sat = 1'b0;
      if (m_acc) begin
        m_bytes.push_back(to_byte(in_data));
        if (out_of_range(in_data)) m_sat = 1'b1;
      end
      if (m_pop) void'(m_words.pop_front());
      if (m_bytes.size() == 4) begin
        m_words.push_back(pad_word());
        m_bytes.delete();
      end else if (m_pend) begin
        if (!m_was_full) begin
          m_words.push_back(pad_word());
          m_bytes.delete();
          m_pend = 1'b0;
        end
      end else if (flush && (m_bytes.size() != 0)) begin
        if (!m_was_full) begin
          m_words.push_back(pad_word());
          m_bytes.delete();
        end else begin
          m_pend = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("count", 32'(count), 32'(m_words.size()));
    check("empty", 32'(empty), 32'(m_words.size() == 0));
    check("full", 32'(full), 32'(m_words.size() == DEPTH));
    check("rd_data", rd_data, (m_words.size() != 0) ? m_words[0] : 32'h0);
    check("lane", 32'(lane), 32'(m_bytes.size()));
    check("flush_busy", 32'(flush_busy), 32'(m_pend));
    check("in_ready", 32'(in_ready), 32'(m_ready()));
`ifdef CONV1D_OUT_PACKER_SAT_CHECK_EN
    check("sat_err", 32'(sat_err), 32'(m_sat));
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 200) begin
      step();
      waited++;
    end
    if (waited == 200) check("send_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_lane", 32'(lane), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rd_data", rd_data, 32'h0);
    rst_n = 1'b1;
    step();

    // Four bytes pack little-endian.
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    check("pack4_rd_data", rd_data, 32'h04030201);
    check("pack4_count", 32'(count), 32'd1);
    check("pack4_lane", 32'(lane), 32'd0);
    pop1();

    // Partial flush zero-pads upper lanes.
    send(32'hFFFFFF85); send(32'd7);
    pulse_flush();
    check("flush_rd_data", rd_data, 32'h00000785);
    check("flush_lane", 32'(lane), 32'd0);
    pop1();

    // Fill the FIFO, then stall a result behind full at lane 3.
    for (int i = 0; i < 256; i++) send(32'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_lane", 32'(lane), 32'd0);
    send(32'hF0); send(32'hF1); send(32'hF2);
    check("stall_lane", 32'(lane), 32'd3);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h13;
    step();
    check("stall_hold", 32'(in_ready), 32'd0);
    pop1();
    check("stall_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("stall_done_count", 32'(count), 32'd64);

    // Flush against a full FIFO waits for space.
    send(32'hAA); send(32'hBB);
    pulse_flush();
    check("pend_busy", 32'(flush_busy), 32'd1);
    check("pend_in_ready", 32'(in_ready), 32'd0);
    step();
    pop1();
    check("pend_still_busy", 32'(flush_busy), 32'd1);
    step();
    check("pend_done_busy", 32'(flush_busy), 32'd0);
    check("pend_done_lane", 32'(lane), 32'd0);
    rd_en = 1'b1;
    repeat (62) step();
    check("drain_stalled_word", rd_data, 32'h13F2F1F0);
    step();
    check("drain_flushed_word", rd_data, 32'h0000BBAA);
    step();
    rd_en = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);

    // Push and pop together keep the count.
    for (int j = 0; j < 20; j++) send(32'h20 + 32'(j));
    send(32'h50); send(32'h51); send(32'h52);
    in_valid = 1'b1;
    in_data  = 32'h53;
    rd_en    = 1'b1;
    step();
    in_valid = 1'b0;
    rd_en    = 1'b0;
    check("pushpop_count", 32'(count), 32'd5);
    check("pushpop_head", rd_data, 32'h27262524);
    rd_en = 1'b1;
    repeat (7) step();
    rd_en = 1'b0;
    check("empty_pop_count", 32'(count), 32'd0);
    send(32'h61); send(32'h62); send(32'h63); send(32'h64);
    check("after_empty_pop", rd_data, 32'h64636261);
    pop1();

    // Asynchronous reset mid-cycle with data queued and a partial word.
    for (int k = 0; k < 43; k++) send(32'(k));
    check("pre_rst_count", 32'(count), 32'd10);
    check("pre_rst_lane", 32'(lane), 32'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_lane", 32'(lane), 32'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef CONV1D_OUT_PACKER_SAT_CHECK_EN
    send(32'd300); send(32'hFFFFFF38);
    check("sat_err_set", 32'(sat_err), 32'd1);
    step();
    check("sat_err_sticky", 32'(sat_err), 32'd1);
    pulse_flush();
    check("sat_word", rd_data, 32'h0000807F);
    check("sat_err_clear", 32'(sat_err), 32'd0);
    pop1();
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
